control_subcmd_fillrect_pattern: RTL and testbench

//  Rectangle-fill sub-command engine: writes a pattern (solid, checker, H/V stripes) into the frame buffer
//  one colour byte per cycle, through the same row/column/pixel write port as the existing fill sub-command.

---
 rtl/control_subcmd_fillrect_pattern_pkg.sv | 27 ++
 rtl/control_subcmd_fillrect_pattern_if.sv | 58 +++++
 rtl/control_subcmd_fillrect_pattern_sel.sv | 42 ++++
 rtl/control_subcmd_fillrect_pattern.sv | 204 ++++++++++++++++++++
 tb/tb_control_subcmd_fillrect_pattern.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_subcmd_fillrect_pattern_pkg.sv
// Shared types and panel defaults for the rectangle pattern-fill engine.
// Holds the fill mode and FSM state enums plus a width helper.
package control_subcmd_fillrect_pattern_pkg;

   localparam int PIXEL_HEIGHT    = 32;
   localparam int BYTES_PER_PIXEL = 3;

   typedef enum logic [1:0] {
      SOLID   = 2'd0,
      CHECKER = 2'd1,
      HSTRIPE = 2'd2,
      VSTRIPE = 2'd3
   } fill_mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fillrect_state_t;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/control_subcmd_fillrect_pattern_if.sv
// Decoder <-> fill engine bundle: command fields in, byte-write port
// and done/busy status out. master = decoder side, slave = engine side.
interface control_subcmd_fillrect_pattern_if #(
   parameter int PIXEL_WIDTH     = 64,
   parameter int PIXEL_HEIGHT    =
      control_subcmd_fillrect_pattern_pkg::PIXEL_HEIGHT,
   parameter int BYTES_PER_PIXEL =
      control_subcmd_fillrect_pattern_pkg::BYTES_PER_PIXEL,
   parameter int NUM_LAYERS      = 2
);
   import control_subcmd_fillrect_pattern_pkg::*;

   localparam int CW = $clog2(PIXEL_WIDTH);
   localparam int RW = $clog2(PIXEL_HEIGHT);
   localparam int PW = clog2_min1(BYTES_PER_PIXEL);
   localparam int CB = 8 * BYTES_PER_PIXEL;
   localparam int LW = clog2_min1(NUM_LAYERS);
   localparam int WW = $clog2(PIXEL_WIDTH + 1);
   localparam int HW = $clog2(PIXEL_HEIGHT + 1);

   logic          enable;
   logic          ack;
   logic [CW-1:0] x1;
   logic [RW-1:0] y1;
   logic [WW-1:0] width;
   logic [HW-1:0] height;
   fill_mode_t    mode;
   logic [CB-1:0] color_a;
   logic [CB-1:0] color_b;
   logic [LW-1:0] layer;

   logic [RW-1:0] row;
   logic [CW-1:0] column;
   logic [PW-1:0] pixel;
   logic [LW-1:0] layer_out;
   logic [7:0]    data_out;
   logic          ram_write_enable;
   logic          ram_access_start;
   logic          done;
   logic          busy;

   modport master (
      output enable, ack, x1, y1, width, height,
      output mode, color_a, color_b, layer,
      input  row, column, pixel, layer_out, data_out,
      input  ram_write_enable, ram_access_start,
      input  done, busy
   );

   modport slave (
      input  enable, ack, x1, y1, width, height,
      input  mode, color_a, color_b, layer,
      output row, column, pixel, layer_out, data_out,
      output ram_write_enable, ram_access_start,
      output done, busy
   );

endinterface

// File: rtl/control_subcmd_fillrect_pattern_sel.sv
// Pattern bit from mode and panel row/column, then colour mux and
// byte select. Ports: mode/row/col/colours/pixel in, data byte out.
module control_subcmd_fillrect_pattern_sel
   import control_subcmd_fillrect_pattern_pkg::*;
#(
   parameter int CW        = 6,
   parameter int RW        = 5,
   parameter int PW        = 2,
   parameter int CB        = 24,
   parameter int CELL_LOG2 = 2
) (
   input  fill_mode_t    mode_i,
   input  logic [RW-1:0] row_i,
   input  logic [CW-1:0] col_i,
   input  logic [CB-1:0] color_a_i,
   input  logic [CB-1:0] color_b_i,
   input  logic [PW-1:0] pixel_i,
   output logic [7:0]    data_o
);

   logic          row_bit;
   logic          col_bit;
   logic          pat;
   logic [CB-1:0] sel_color;

   // Cell parity is bit CELL_LOG2 of the coordinate; a cell wider
   // than the panel yields a constant 0.
   always_comb begin
      row_bit = |(row_i & (RW'(1) << CELL_LOG2));
      col_bit = |(col_i & (CW'(1) << CELL_LOG2));
      pat     = 1'b0;
      unique case (mode_i)
         SOLID:   pat = 1'b0;
         CHECKER: pat = row_bit ^ col_bit;
         HSTRIPE: pat = row_bit;
         VSTRIPE: pat = col_bit;
      endcase
      sel_color = pat ? color_b_i : color_a_i;
      data_o    = 8'(sel_color >> {pixel_i, 3'b000});
   end

endmodule

// File: rtl/control_subcmd_fillrect_pattern.sv
// Rectangle pattern fill: one colour byte per cycle, bottom-right to
// top-left, bytes high to low. Ports: clk, reset (async, low),
// bus (slave: command in, write port + done/busy out).
// Build option FILLRECT_CLIP_EN: skip off-panel rows/columns;
// otherwise coordinates wrap modulo the panel size.
module control_subcmd_fillrect_pattern #(
   parameter int PIXEL_WIDTH     = 64,
   parameter int PIXEL_HEIGHT    =
      control_subcmd_fillrect_pattern_pkg::PIXEL_HEIGHT,
   parameter int BYTES_PER_PIXEL =
      control_subcmd_fillrect_pattern_pkg::BYTES_PER_PIXEL,
   parameter int NUM_LAYERS      = 2,
   parameter int CELL_LOG2       = 2
) (
   input logic clk,
   input logic reset,
   control_subcmd_fillrect_pattern_if.slave bus
);
   import control_subcmd_fillrect_pattern_pkg::*;

   localparam int CW = $clog2(PIXEL_WIDTH);
   localparam int RW = $clog2(PIXEL_HEIGHT);
   localparam int PW = clog2_min1(BYTES_PER_PIXEL);
   localparam int CB = 8 * BYTES_PER_PIXEL;
   localparam int LW = clog2_min1(NUM_LAYERS);
   localparam int XW = CW + 1;
   localparam int YW = RW + 1;

   localparam logic [XW-1:0] X_MAX = XW'(PIXEL_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(PIXEL_HEIGHT - 1);
   localparam logic [PW-1:0] P_TOP = PW'(BYTES_PER_PIXEL - 1);

   fillrect_state_t state_q, state_d;
   logic            arm_q, arm_d;
   logic            first_q, first_d;
   fill_mode_t      mode_q, mode_d;
   logic [CB-1:0]   ca_q, ca_d;
   logic [CB-1:0]   cb_q, cb_d;
   logic [LW-1:0]   layer_q, layer_d;
   logic [XW-1:0]   x1_q, x1_d;
   logic [XW-1:0]   xs_q, xs_d;
   logic [XW-1:0]   col_q, col_d;
   logic [YW-1:0]   y1_q, y1_d;
   logic [YW-1:0]   row_q, row_d;
   logic [PW-1:0]   pix_q, pix_d;

   logic [XW-1:0]   x_end;
   logic [YW-1:0]   y_end;
   logic [XW-1:0]   x_start;
   logic [YW-1:0]   y_start;
   logic            empty;
   logic            wr;
   logic [7:0]      byte_w;

   // End corner kept one bit wider so it never truncates.
   always_comb begin
      x_end = {1'b0, bus.x1} + XW'(bus.width) - XW'(1);
      y_end = {1'b0, bus.y1} + YW'(bus.height) - YW'(1);
      empty = (bus.width == '0) || (bus.height == '0);
`ifdef FILLRECT_CLIP_EN
      x_start = (x_end > X_MAX) ? X_MAX : x_end;
      y_start = (y_end > Y_MAX) ? Y_MAX : y_end;
      empty   = empty
              || ({1'b0, bus.x1} > X_MAX)
              || ({1'b0, bus.y1} > Y_MAX);
`else
      x_start = x_end;
      y_start = y_end;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         arm_q   <= 1'b1;
         first_q <= 1'b0;
         mode_q  <= SOLID;
         ca_q    <= '0;
         cb_q    <= '0;
         layer_q <= '0;
         x1_q    <= '0;
         xs_q    <= '0;
         col_q   <= '0;
         y1_q    <= '0;
         row_q   <= '0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm_d;
         first_q <= first_d;
         mode_q  <= mode_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         layer_q <= layer_d;
         x1_q    <= x1_d;
         xs_q    <= xs_d;
         col_q   <= col_d;
         y1_q    <= y1_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
      end
   end

   // arm_q: a new fill needs enable to have been low since the
   // last start, so a held enable cannot retrigger.
   always_comb begin
      state_d = state_q;
      arm_d   = arm_q | ~bus.enable;
      first_d = first_q;
      mode_d  = mode_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      layer_d = layer_q;
      x1_d    = x1_q;
      xs_d    = xs_q;
      col_d   = col_q;
      y1_d    = y1_q;
      row_d   = row_q;
      pix_d   = pix_q;
      unique case (state_q)
         IDLE: begin
            if (bus.enable && arm_q) begin
               state_d = SETUP;
               arm_d   = 1'b0;
            end
         end
         SETUP: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else begin
               mode_d  = bus.mode;
               ca_d    = bus.color_a;
               cb_d    = bus.color_b;
               layer_d = bus.layer;
               x1_d    = {1'b0, bus.x1};
               y1_d    = {1'b0, bus.y1};
               xs_d    = x_start;
               col_d   = x_start;
               row_d   = y_start;
               pix_d   = P_TOP;
               first_d = 1'b1;
               state_d = empty ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (!bus.enable) begin
               state_d = IDLE;
            end else begin
               first_d = 1'b0;
               if (pix_q != '0) begin
                  pix_d = pix_q - PW'(1);
               end else begin
                  pix_d = P_TOP;
                  if (col_q != x1_q) begin
                     col_d = col_q - XW'(1);
                  end else begin
                     col_d = xs_q;
                     if (row_q != y1_q) begin
                        row_d = row_q - YW'(1);
                     end else begin
                        state_d = DONE;
                     end
                  end
               end
            end
         end
         DONE: begin
            if (bus.ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   control_subcmd_fillrect_pattern_sel #(
      .CW        (CW),
      .RW        (RW),
      .PW        (PW),
      .CB        (CB),
      .CELL_LOG2 (CELL_LOG2)
   ) u_sel (
      .mode_i    (mode_q),
      .row_i     (row_q[RW-1:0]),
      .col_i     (col_q[CW-1:0]),
      .color_a_i (ca_q),
      .color_b_i (cb_q),
      .pixel_i   (pix_q),
      .data_o    (byte_w)
   );

   // Dropping the top coordinate bit gives the modulo-panel wrap.
   assign wr                   = (state_q == WRITE);
   assign bus.ram_write_enable = wr;
   assign bus.ram_access_start = wr & first_q;
   assign bus.done             = (state_q == DONE);
   assign bus.busy             = (state_q != IDLE);
   assign bus.row              = wr ? row_q[RW-1:0] : '0;
   assign bus.column           = wr ? col_q[CW-1:0] : '0;
   assign bus.pixel            = wr ? pix_q : '0;
   assign bus.layer_out        = wr ? layer_q : '0;
   assign bus.data_out         = wr ? byte_w : '0;

endmodule

// File: tb/tb_control_subcmd_fillrect_pattern.sv
// Self-checking bench for control_subcmd_fillrect_pattern: scoreboard of
// expected byte writes from a loop-based model, checked by a monitor.
module tb_control_subcmd_fillrect_pattern;
   import control_subcmd_fillrect_pattern_pkg::*;

   localparam int PWID = 64;
   localparam int PH   = PIXEL_HEIGHT;
   localparam int BPP  = BYTES_PER_PIXEL;
   localparam int NL   = 2;
   localparam int CL   = 0;
   localparam int CW   = $clog2(PWID);
   localparam int RW   = $clog2(PH);
   localparam int PW   = clog2_min1(BPP);
   localparam int CB   = 8 * BPP;
   localparam int LW   = clog2_min1(NL);
   localparam int WW   = $clog2(PWID + 1);
   localparam int HW   = $clog2(PH + 1);

   typedef struct {
      int row;
      int col;
      int pix;
      int layer;
      int data;
      bit start;
   } exp_t;

   exp_t       exp_q[$];
   logic       clk = 1'b0;
   logic       reset;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         mon_on = 1'b0;
   int         wr_cnt = 0;
   logic [7:0] mem [NL][PH][PWID][BPP];

   control_subcmd_fillrect_pattern_if #(
      .PIXEL_WIDTH     (PWID),
      .PIXEL_HEIGHT    (PH),
      .BYTES_PER_PIXEL (BPP),
      .NUM_LAYERS      (NL)
   ) bus ();

   control_subcmd_fillrect_pattern #(
      .PIXEL_WIDTH     (PWID),
      .PIXEL_HEIGHT    (PH),
      .BYTES_PER_PIXEL (BPP),
      .NUM_LAYERS      (NL),
      .CELL_LOG2       (CL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act,
                               logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endfunction

   function automatic logic [63:0] pk(int r, int c, int p, int l,
                                      int d, bit s);
      return {16'd0, 8'(r), 8'(c), 8'(p), 8'(l), 8'(d), 8'(s)};
   endfunction

   function automatic logic [63:0] outs();
      return 64'({bus.row, bus.column, bus.pixel, bus.layer_out,
                  bus.data_out, bus.ram_write_enable,
                  bus.ram_access_start, bus.done, bus.busy});
   endfunction

   function automatic logic [CB-1:0] pix_val(int l, int r, int c);
      logic [CB-1:0] v;
      v = '0;
      for (int p = 0; p < BPP; p++) v[8*p +: 8] = mem[l][r][c][p];
      return v;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.ram_write_enable === 1'b1) begin
         wr_cnt++;
         mem[bus.layer_out][bus.row][bus.column][bus.pixel] =
            bus.data_out;
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got r%0d c%0d p%0d want none",
                        bus.row, bus.column, bus.pixel);
            end else begin
               e = exp_q.pop_front();
               chk("write",
                   pk(int'(bus.row), int'(bus.column), int'(bus.pixel),
                      int'(bus.layer_out), int'(bus.data_out),
                      bus.ram_access_start),
                   pk(e.row, e.col, e.pix, e.layer, e.data, e.start));
            end
         end
      end else if (mon_on && bus.ram_access_start === 1'b1) begin
         chk("start_without_write", 64'(bus.ram_access_start), 64'd0);
      end
   end

   // Reference: walk the rectangle bottom-right to top-left.
   task automatic model_fill(input int x1, input int y1, input int w,
                             input int h, input int m,
                             input logic [CB-1:0] ca,
                             input logic [CB-1:0] cb,
                             input int ly, output int n);
      exp_t          e;
      int            rr, cc, bv;
      logic [CB-1:0] col;
      bit            first;
      first = 1'b1;
      n = 0;
      for (int r = y1 + h - 1; r >= y1; r--) begin
`ifdef FILLRECT_CLIP_EN
         if (r >= PH) continue;
`endif
         for (int c = x1 + w - 1; c >= x1; c--) begin
`ifdef FILLRECT_CLIP_EN
            if (c >= PWID) continue;
`endif
            rr = r % PH;
            cc = c % PWID;
            case (m)
               0:       bv = 0;
               1:       bv = ((rr >> CL) ^ (cc >> CL)) & 1;
               2:       bv = (rr >> CL) & 1;
               default: bv = (cc >> CL) & 1;
            endcase
            col = (bv != 0) ? cb : ca;
            for (int p = BPP - 1; p >= 0; p--) begin
               e.row   = rr;
               e.col   = cc;
               e.pix   = p;
               e.layer = ly;
               e.data  = int'((col >> (8 * p)) & CB'(8'hFF));
               e.start = first;
               first   = 1'b0;
               exp_q.push_back(e);
               n++;
            end
         end
      end
   endtask

   task automatic drive_cmd(input int x1, input int y1, input int w,
                            input int h, input int m,
                            input logic [CB-1:0] ca,
                            input logic [CB-1:0] cb, input int ly);
      bus.x1      = CW'(x1);
      bus.y1      = RW'(y1);
      bus.width   = WW'(w);
      bus.height  = HW'(h);
      bus.mode    = fill_mode_t'(2'(m));
      bus.color_a = ca;
      bus.color_b = cb;
      bus.layer   = LW'(ly);
      bus.enable  = 1'b1;
   endtask

   task automatic scramble();
      bus.x1      = CW'($urandom);
      bus.y1      = RW'($urandom);
      bus.width   = WW'($urandom);
      bus.height  = HW'($urandom);
      bus.mode    = fill_mode_t'(2'($urandom));
      bus.color_a = CB'($urandom);
      bus.color_b = CB'($urandom);
      bus.layer   = LW'($urandom);
   endtask

   task automatic run_fill(input int x1, input int y1, input int w,
                           input int h, input int m,
                           input logic [CB-1:0] ca,
                           input logic [CB-1:0] cb, input int ly);
      int n, cyc, hold;
      bit got;
      model_fill(x1, y1, w, h, m, ca, cb, ly, n);
      @(negedge clk);
      drive_cmd(x1, y1, w, h, m, ca, cb, ly);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < n + 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 2) begin
            scramble();
            if (n > 1) bus.ack = 1'($urandom);
         end
         if (cyc == n + 1) bus.ack = 1'b0;
         if (bus.done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done want done by %0d", n + 2);
         bus.enable = 1'b0;
         bus.ack    = 1'b0;
         reset      = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         exp_q.delete();
         @(negedge clk);
         return;
      end
      chk("done_latency", 64'(cyc), 64'(n + 2));
      chk("writes_left", 64'(exp_q.size()), 64'd0);
      hold = $urandom_range(0, 3);
      repeat (hold) begin
         @(negedge clk);
         chk("done_hold", 64'(bus.done), 64'd1);
      end
      bus.ack = 1'b1;
      @(negedge clk);
      chk("ack_idle", 64'({bus.done, bus.busy}), 64'd0);
      bus.ack = 1'b0;
      @(negedge clk);
      chk("no_restart", 64'(bus.busy), 64'd0);
      bus.enable = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c0, nz, w, h;
      bit any;
      reset      = 1'b0;
      bus.enable = 1'b0;
      bus.ack    = 1'b0;
      scramble();
      for (int l = 0; l < NL; l++)
         for (int r = 0; r < PH; r++)
            for (int c = 0; c < PWID; c++)
               for (int p = 0; p < BPP; p++) mem[l][r][c][p] = 8'hFF;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 64'(bus.busy), 64'd0);
      mon_on = 1'b1;

      // Full panel solid fill over a 0xFF-preset layer
      run_fill(0, 0, PWID, PH, 0, '0, CB'($urandom), 0);
      nz = 0;
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PWID; c++)
            if (pix_val(0, r, c) != '0) nz++;
      chk("full_panel_zero", 64'(nz), 64'd0);

      // 4x2 checker, one-pixel cells
      run_fill(0, 0, 4, 2, 1, CB'(24'h112233), CB'(24'hAABBCC), 1);
      chk("chk_0_0", 64'(pix_val(1, 0, 0)), 64'h112233);
      chk("chk_1_0", 64'(pix_val(1, 0, 1)), 64'hAABBCC);
      chk("chk_0_1", 64'(pix_val(1, 1, 0)), 64'hAABBCC);

      // Empty rectangles
      c0 = wr_cnt;
      run_fill(5, 5, 0, 3, 2, CB'($urandom), CB'($urandom), 0);
      run_fill(9, 2, 7, 0, 3, CB'($urandom), CB'($urandom), 1);
      chk("empty_no_writes", 64'(wr_cnt - c0), 64'd0);

      // Abort by dropping enable mid-write
      mon_on = 1'b0;
      @(negedge clk);
      drive_cmd(3, 3, 8, 8, 1, CB'($urandom), CB'($urandom), 0);
      repeat (6) @(negedge clk);
      chk("abort_writing", 64'(bus.ram_write_enable), 64'd1);
      bus.enable = 1'b0;
      @(negedge clk);
      chk("abort_idle", 64'({bus.ram_write_enable, bus.busy}), 64'd0);
      any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         any = any | bus.ram_write_enable | bus.done | bus.busy;
      end
      chk("abort_quiet", 64'(any), 64'd0);
      mon_on = 1'b1;

      // Reset mid-fill, then a fresh fill
      mon_on = 1'b0;
      @(negedge clk);
      drive_cmd(10, 4, 6, 5, 2, CB'($urandom), CB'($urandom), 1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("reset_mid_fill", outs(), 64'd0);
      bus.enable = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_q.delete();
      mon_on = 1'b1;
      run_fill(20, 10, 5, 3, 1, CB'($urandom), CB'($urandom), 1);

      // Right-edge overhang: clip or wrap
      c0 = wr_cnt;
      run_fill(PWID - 2, 7, 4, 1, 3, CB'($urandom), CB'($urandom), 0);
`ifdef FILLRECT_CLIP_EN
      chk("edge_count", 64'(wr_cnt - c0), 64'(2 * BPP));
`else
      chk("edge_count", 64'(wr_cnt - c0), 64'(4 * BPP));
`endif

      // Randomized fills, including panel-edge overhangs
      for (int i = 0; i < 30; i++) begin
         w = ($urandom_range(0, 9) == 0) ? PWID : $urandom_range(0, 12);
         h = ($urandom_range(0, 9) == 0) ? PH : $urandom_range(0, 6);
         run_fill($urandom_range(0, PWID - 1), $urandom_range(0, PH - 1),
                  w, h, $urandom_range(0, 3), CB'($urandom),
                  CB'($urandom), $urandom_range(0, NL - 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
